bp_fe_ras_multi: RTL and testbench

- Parametrised multi-entry return address stack for the front-end PC generator.
- Replaces the single-register return address with a circular stack of configurable depth.
- Supports checkpoint export (pointer plus count) for branch metadata, and restore on backend redirect.
- Sits beside BTB/BHT in PC gen; push on fetched call, pop on fetched return, restore on redirect.

---
 rtl/bp_fe_ras_multi_if.sv | 34 +++
 rtl/bp_fe_ras_multi.sv | 82 ++++++++
 tb/tb_bp_fe_ras_multi.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bp_fe_ras_multi_if.sv
// Return address stack request/response bundle.
// Master drives push/pop/restore, slave returns top and checkpoint.
interface bp_fe_ras_multi_if #(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = 8
);
  localparam int ptr_width_lp =
    (ras_els_p == 1) ? 1 : $clog2(ras_els_p);
  localparam int cnt_width_lp =
    ((ras_els_p + 1) == 1) ? 1 : $clog2(ras_els_p + 1);

  logic                     push_v_i;
  logic [vaddr_width_p-1:0] push_addr_i;
  logic                     pop_v_i;
  logic                     restore_v_i;
  logic [ptr_width_lp-1:0]  restore_ptr_i;
  logic [cnt_width_lp-1:0]  restore_cnt_i;
  logic [vaddr_width_p-1:0] top_addr_o;
  logic                     top_v_o;
  logic [ptr_width_lp-1:0]  ckpt_ptr_o;
  logic [cnt_width_lp-1:0]  ckpt_cnt_o;

  modport master (
    output push_v_i, push_addr_i, pop_v_i,
    output restore_v_i, restore_ptr_i, restore_cnt_i,
    input  top_addr_o, top_v_o, ckpt_ptr_o, ckpt_cnt_o
  );

  modport slave (
    input  push_v_i, push_addr_i, pop_v_i,
    input  restore_v_i, restore_ptr_i, restore_cnt_i,
    output top_addr_o, top_v_o, ckpt_ptr_o, ckpt_cnt_o
  );
endinterface

// File: rtl/bp_fe_ras_multi.sv
// Multi-entry circular return address stack for PC gen.
// Push on call, pop on return, checkpoint restore on redirect.
module bp_fe_ras_multi #(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = 8
) (
  input logic              clk_i,
  input logic              reset_i,
  bp_fe_ras_multi_if.slave ras
);
  localparam int ptr_width_lp =
    (ras_els_p == 1) ? 1 : $clog2(ras_els_p);
  localparam int cnt_width_lp =
    ((ras_els_p + 1) == 1) ? 1 : $clog2(ras_els_p + 1);
  localparam logic [cnt_width_lp-1:0] full_lp =
    cnt_width_lp'(ras_els_p);

  if ((ras_els_p < 2) || ((ras_els_p & (ras_els_p - 1)) != 0))
  begin : g_bad_els
    $error("ras_els_p must be a power of two >= 2");
  end

  logic [vaddr_width_p-1:0] mem [ras_els_p];
  logic [ptr_width_lp-1:0]  tos_r, tos_n, tos_base, waddr;
  logic [cnt_width_lp-1:0]  cnt_r, cnt_n, cnt_base;
  logic                     we;

  // Pick base (restored or current), then apply push/pop on it
  always_comb begin
    tos_base = tos_r;
    cnt_base = cnt_r;
    if (ras.restore_v_i) begin
      tos_base = ras.restore_ptr_i;
      cnt_base = (ras.restore_cnt_i > full_lp)
               ? full_lp : ras.restore_cnt_i;
    end
    tos_n = tos_base;
    cnt_n = cnt_base;
    waddr = tos_base;
    we    = 1'b0;
    if (ras.push_v_i && ras.pop_v_i && (cnt_base != '0)) begin
      we = 1'b1;
    end else if (ras.push_v_i) begin
      tos_n = tos_base + ptr_width_lp'(1);
      waddr = tos_n;
      we    = 1'b1;
      cnt_n = (cnt_base == full_lp)
            ? full_lp : cnt_base + cnt_width_lp'(1);
    end else if (ras.pop_v_i && (cnt_base != '0)) begin
      tos_n = tos_base - ptr_width_lp'(1);
      cnt_n = cnt_base - cnt_width_lp'(1);
    end
  end

  // Pointer and occupancy, cleared asynchronously
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tos_r <= '0;
      cnt_r <= '0;
    end else begin
      tos_r <= tos_n;
      cnt_r <= cnt_n;
    end
  end

  // Entry array is never cleared; stale entries aid restore
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= ras.push_addr_i;
  end

  // Checkpoint counts above capacity indicate a metadata bug
  always_ff @(posedge clk_i) begin
    if (!reset_i && ras.restore_v_i)
      assert (ras.restore_cnt_i <= full_lp)
        else $error("restore_cnt_i exceeds ras_els_p");
  end

  assign ras.top_addr_o = mem[tos_r];
  assign ras.top_v_o    = (cnt_r != '0);
  assign ras.ckpt_ptr_o = tos_r;
  assign ras.ckpt_cnt_o = cnt_r;
endmodule

// File: tb/tb_bp_fe_ras_multi.sv
// Self-checking bench for bp_fe_ras_multi (4 entries).
// Vector table plus scoreboard queue and async reset sequence.
module tb_bp_fe_ras_multi;
  localparam int VW = 39;
  localparam int EL = 4;

  typedef struct {
    logic          rst;
    logic          push;
    logic [VW-1:0] addr;
    logic          pop;
    logic          rv;
    logic [1:0]    rptr;
    logic [2:0]    rcnt;
    logic          ev;
    logic [VW-1:0] etop;
    logic [1:0]    eptr;
    logic [2:0]    ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   asserts = 0;
  int   failures = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  bp_fe_ras_multi_if #(.vaddr_width_p(VW), .ras_els_p(EL)) ras_if ();

  bp_fe_ras_multi #(.vaddr_width_p(VW), .ras_els_p(EL)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .ras    (ras_if)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic rst, logic push, logic [VW-1:0] addr, logic pop,
    logic rv, logic [1:0] rptr, logic [2:0] rcnt,
    logic ev, logic [VW-1:0] etop, logic [1:0] eptr,
    logic [2:0] ecnt);
    vec_t v;
    v.rst = rst; v.push = push; v.addr = addr; v.pop = pop;
    v.rv = rv; v.rptr = rptr; v.rcnt = rcnt;
    v.ev = ev; v.etop = etop; v.eptr = eptr; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] req);
    asserts++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic idle();
    ras_if.push_v_i      = 1'b0;
    ras_if.push_addr_i   = '0;
    ras_if.pop_v_i       = 1'b0;
    ras_if.restore_v_i   = 1'b0;
    ras_if.restore_ptr_i = '0;
    ras_if.restore_cnt_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_exp(string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      cmp({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, "_top_v"}, 64'(ras_if.top_v_o), 64'(e.ev));
    cmp({tag, "_ptr"}, 64'(ras_if.ckpt_ptr_o), 64'(e.eptr));
    cmp({tag, "_cnt"}, 64'(ras_if.ckpt_cnt_o), 64'(e.ecnt));
    if (e.ev)
      cmp({tag, "_top"}, 64'(ras_if.top_addr_o), 64'(e.etop));
  endtask

  task automatic step(vec_t v, string tag);
    if (v.rst) do_reset();
    @(negedge clk);
    ras_if.push_v_i      = v.push;
    ras_if.push_addr_i   = v.addr;
    ras_if.pop_v_i       = v.pop;
    ras_if.restore_v_i   = v.rv;
    ras_if.restore_ptr_i = v.rptr;
    ras_if.restore_cnt_i = v.rcnt;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_exp(tag);
  endtask

  initial begin
    idle();
    // three pushes then three pops
    tbl.push_back(mk(1,1,'h100,0,0,0,0, 1,'h100,1,1));
    tbl.push_back(mk(0,1,'h200,0,0,0,0, 1,'h200,2,2));
    tbl.push_back(mk(0,1,'h300,0,0,0,0, 1,'h300,3,3));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   1,'h200,2,2));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   1,'h100,1,1));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   0,'h0,0,0));
    // saturation with wrap-around, then underflow
    tbl.push_back(mk(1,1,'h10,0,0,0,0,  1,'h10,1,1));
    tbl.push_back(mk(0,1,'h20,0,0,0,0,  1,'h20,2,2));
    tbl.push_back(mk(0,1,'h30,0,0,0,0,  1,'h30,3,3));
    tbl.push_back(mk(0,1,'h40,0,0,0,0,  1,'h40,0,4));
    tbl.push_back(mk(0,1,'h50,0,0,0,0,  1,'h50,1,4));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   1,'h40,0,3));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   1,'h30,3,2));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   1,'h20,2,1));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   0,'h0,1,0));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   0,'h0,1,0));
    tbl.push_back(mk(0,0,'h0,0,0,0,0,   0,'h0,1,0));
    // replace-top
    tbl.push_back(mk(1,1,'hA0,0,0,0,0,  1,'hA0,1,1));
    tbl.push_back(mk(0,1,'hB0,1,0,0,0,  1,'hB0,1,1));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,   0,'h0,0,0));
    tbl.push_back(mk(0,1,'hC0,1,0,0,0,  1,'hC0,1,1));
    // checkpoint and restore
    tbl.push_back(mk(1,1,'h1000,0,0,0,0, 1,'h1000,1,1));
    tbl.push_back(mk(0,1,'h2000,0,0,0,0, 1,'h2000,2,2));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,    1,'h1000,1,1));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,    0,'h0,0,0));
    tbl.push_back(mk(0,1,'h3000,0,0,0,0, 1,'h3000,1,1));
    tbl.push_back(mk(0,0,'h0,0,1,2,2,    1,'h2000,2,2));
    tbl.push_back(mk(0,0,'h0,1,0,0,0,    1,'h3000,1,1));
    tbl.push_back(mk(0,1,'h4444,0,1,1,1, 1,'h4444,2,2));
    tbl.push_back(mk(0,0,'h0,1,1,2,2,    1,'h3000,1,1));
    tbl.push_back(mk(0,1,'h5555,1,1,2,2, 1,'h5555,2,2));
    tbl.push_back(mk(0,0,'h0,1,1,3,0,    0,'h0,3,0));
    tbl.push_back(mk(0,1,'h6666,1,1,0,0, 1,'h6666,1,1));
    tbl.push_back(mk(0,1,'h7777,0,1,3,4, 1,'h7777,0,4));

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cmp("reset_top_v", 64'(ras_if.top_v_o), 64'd0);
    cmp("reset_ptr", 64'(ras_if.ckpt_ptr_o), 64'd0);
    cmp("reset_cnt", 64'(ras_if.ckpt_cnt_o), 64'd0);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset between clock edges with cnt=3
    step(mk(1,1,'h1,0,0,0,0, 1,'h1,1,1), "ar_p1");
    step(mk(0,1,'h2,0,0,0,0, 1,'h2,2,2), "ar_p2");
    step(mk(0,1,'h3,0,0,0,0, 1,'h3,3,3), "ar_p3");
    @(negedge clk);
    idle();
    #2;
    reset = 1'b1;
    #1;
    cmp("async_top_v", 64'(ras_if.top_v_o), 64'd0);
    cmp("async_cnt", 64'(ras_if.ckpt_cnt_o), 64'd0);
    cmp("async_ptr", 64'(ras_if.ckpt_ptr_o), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    step(mk(0,1,'h77,0,0,0,0, 1,'h77,1,1), "ar_post");

    cmp("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, failures);
    $finish;
  end
endmodule
